// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the architectural datapath width reused by the ALU and EX-stage code.
package mdu_hilo_pkg;

  localparam int MDU_W = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_dvd_bit,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_rem,
  output logic         o_q_bit
);

  logic [W:0]   w_shift;
  logic [W-1:0] w_diff;

  assign w_shift = {i_rem, i_dvd_bit};
  // Only consumed when the divisor fits, so the true difference is below 2^W.
  assign w_diff  = w_shift[W-1:0] - i_divisor;
  assign o_q_bit = (w_shift >= {1'b0, i_divisor});
  assign o_rem   = o_q_bit ? w_diff : w_shift[W-1:0];

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO registers: single-cycle
// registered multiply, W-step restoring divide with a final sign-fixup cycle.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int W  = MDU_W,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic         cancel,
  input  logic [W-1:0] srcA,
  input  logic [W-1:0] srcB,
  output logic         busy,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  mdu_state_e            r_state;
  logic                  r_busy;
  logic [CW-1:0]         r_cnt;
  logic [W-1:0]          r_hi;
  logic [W-1:0]          r_lo;
  logic signed [2*W-1:0] r_prod;
  logic [W-1:0]          r_dvd;
  logic [W-1:0]          r_dvs;
  logic [W-1:0]          r_rem;
  logic                  r_sign_q;
  logic                  r_sign_r;

  logic                  w_mul_signed;
  logic signed [2*W-1:0] w_a_ext;
  logic signed [2*W-1:0] w_b_ext;
  logic signed [2*W-1:0] w_prod;
  logic                  w_div_signed;
  logic                  w_neg_a;
  logic                  w_neg_b;
  logic [W-1:0]          w_mag_a;
  logic [W-1:0]          w_mag_b;
  logic [W-1:0]          w_rem_nxt;
  logic                  w_qbit;
  logic                  w_launch;

  function automatic logic [W-1:0] apply_sign(input logic neg, input logic [W-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // One 2W x 2W multiplier serves both MULT and MULTU; only the extension differs.
  assign w_mul_signed = (op == MDU_MULT);
  assign w_a_ext      = {{W{w_mul_signed & srcA[W-1]}}, srcA};
  assign w_b_ext      = {{W{w_mul_signed & srcB[W-1]}}, srcB};
  assign w_prod       = w_a_ext * w_b_ext;

  // The unsigned magnitude of 0x80000000 is itself, so W bits suffice.
  assign w_div_signed = (op == MDU_DIV);
  assign w_neg_a      = w_div_signed & srcA[W-1];
  assign w_neg_b      = w_div_signed & srcB[W-1];
  assign w_mag_a      = apply_sign(w_neg_a, srcA);
  assign w_mag_b      = apply_sign(w_neg_b, srcB);

  assign w_launch     = (r_state == ST_IDLE) && start;

  mdu_div_step #(.W(W)) u_div_step (
    .i_rem     (r_rem),
    .i_dvd_bit (r_dvd[W-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_nxt),
    .o_q_bit   (w_qbit)
  );

  // Operand/working registers: no reset, their contents only matter in flight.
  always_ff @(posedge clk) begin
    if (w_launch && (op == MDU_MULT || op == MDU_MULTU)) begin
      r_prod <= w_prod;
    end
    if (w_launch && (op == MDU_DIV || op == MDU_DIVU)) begin
      r_dvd    <= w_mag_a;
      r_dvs    <= w_mag_b;
      r_rem    <= '0;
      r_sign_q <= w_neg_a ^ w_neg_b;
      r_sign_r <= w_neg_a;
    end else if (r_state == ST_DIV) begin
      // Dividend register shifts out MSB-first and collects the quotient at the LSB.
      r_rem <= w_rem_nxt;
      r_dvd <= {r_dvd[W-2:0], w_qbit};
    end
  end

  // Control FSM and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (cancel) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              MDU_MULT, MDU_MULTU: begin
                r_state <= ST_MUL;
                r_busy  <= 1'b1;
              end
              MDU_DIV, MDU_DIVU: begin
                r_state <= ST_DIV;
                r_busy  <= 1'b1;
                r_cnt   <= '0;
              end
              MDU_MTHI: r_hi <= srcA;
              MDU_MTLO: r_lo <= srcA;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          {r_hi, r_lo} <= r_prod;
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
        end
        ST_DIV: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(W - 1)) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_lo    <= apply_sign(r_sign_q, r_dvd);
          r_hi    <= apply_sign(r_sign_r, r_rem);
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo with hand-computed results.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd6;
  logic        cancel = 1'b0;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_err = 0;
  int n_chk = 0;

  mdu_hilo dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .cancel (cancel),
    .srcA   (srcA),
    .srcB   (srcB),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch an op, then count the cycles busy stays high (bounded).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    start = 1'b1; op = o; srcA = a; srcB = b;
    tick();
    start = 1'b0; op = 3'd6;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  // DIV 50/5 with an ignored MULT start at cycle 10; returns at cycle 19.
  task automatic div_with_intrusion();
    start = 1'b1; op = 3'd2; srcA = 32'd50; srcB = 32'd5;
    tick();
    start = 1'b0; op = 3'd6;
    for (int i = 1; i < 10; i++) tick();
    start = 1'b1; op = 3'd0; srcA = 32'd3; srcB = 32'd4;
    tick();
    start = 1'b0; op = 3'd6;
    chk("busy_after_ignored_start", {31'd0, busy}, 32'd1);
    for (int i = 11; i < 20; i++) tick();
  endtask

  initial begin
    int cyc;

    tick(); tick();
    reset = 1'b0;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    run_op(3'd0, 32'hFFFFFFFE, 32'h00000003, cyc);
    chk("mult_cycles", cyc, 32'd1);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    run_op(3'd1, 32'hFFFFFFFE, 32'h00000003, cyc);
    chk("multu_hi", hi, 32'h00000002);
    chk("multu_lo", lo, 32'hFFFFFFFA);

    run_op(3'd2, 32'hFFFFFFF9, 32'h00000002, cyc);
    chk("div_cycles", cyc, 32'd33);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    run_op(3'd3, 32'd100, 32'd7, cyc);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, cyc);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'h0);

    run_op(3'd3, 32'd5, 32'd0, cyc);
    chk("divu_zero_cycles", cyc, 32'd33);
    chk("divu_zero_lo", lo, 32'hFFFFFFFF);
    chk("divu_zero_hi", hi, 32'd5);

    // MTHI then MTLO on consecutive edges.
    start = 1'b1; op = 3'd4; srcA = 32'h12345678;
    tick();
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo_kept", lo, 32'hFFFFFFFF);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    op = 3'd5; srcA = 32'h9ABCDEF0;
    tick();
    start = 1'b0; op = 3'd6;
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", hi, 32'h12345678);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);

    // No-op encodings and cancel-over-start in IDLE.
    start = 1'b1; op = 3'd7; srcA = 32'hDEADBEEF;
    tick();
    chk("noop_busy", {31'd0, busy}, 32'd0);
    chk("noop_hi", hi, 32'h12345678);
    op = 3'd4; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0; op = 3'd6;
    chk("cancel_beats_start_hi", hi, 32'h12345678);

    // Cancel mid-divide.
    div_with_intrusion();
    chk("busy_before_cancel", {31'd0, busy}, 32'd1);
    chk("hi_read_during_busy", hi, 32'h12345678);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 40; i++) tick();
    chk("cancel_hi", hi, 32'h12345678);
    chk("cancel_lo", lo, 32'h9ABCDEF0);
    chk("cancel_busy_later", {31'd0, busy}, 32'd0);

    // Reset mid-divide, then a fresh divide.
    div_with_intrusion();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    run_op(3'd3, 32'd9, 32'd3, cyc);
    chk("divu93_cycles", cyc, 32'd33);
    chk("divu93_lo", lo, 32'd3);
    chk("divu93_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
